// File: rtl/bf_bus_ctrl_pkg.sv
// Shared types for the BF bus controller: core bus operations, controller
// states and the memory region selector bit.
package bf_bus_ctrl_pkg;

  // Bus request issued by the interpreter core. Encodings 6 and 7 are unused.
  typedef enum logic [2:0] {
    BusNone      = 3'd0,
    BusReadProg  = 3'd1,
    BusReadData  = 3'd2,
    BusWriteData = 3'd3,
    BusReadIo    = 3'd4,
    BusWriteIo   = 3'd5
  } BusOp;

  // Controller state, also exported on the debug port.
  typedef enum logic [2:0] {
    Idle    = 3'd0,
    MemWait = 3'd1,
    OutWait = 3'd2,
    InWait  = 3'd3,
    Resume  = 3'd4
  } CtrlState;

  // Top bit of mem_addr: program and data share one physical memory.
  localparam logic REGION_PROG = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  // Region selected by a memory operation.
  function automatic logic op_region(input BusOp op);
    return ((op == BusReadData) || (op == BusWriteData)) ? REGION_DATA : REGION_PROG;
  endfunction

endpackage

// File: rtl/bf_bus_watchdog.sv
// Memory watchdog: counts request cycles that pass without an acknowledge and
// flags the cycle in which the budget of TIMEOUT_CYCLES is used up.
// TIMEOUT_CYCLES = 0 turns the watchdog off entirely.
module bf_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  // Count value during the last permitted request cycle.
  localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

  logic [TO_WIDTH-1:0] to_cnt;

  // Count unacknowledged request cycles; cleared whenever no request is pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (clear) begin
      to_cnt <= '0;
    end else if (enable && ENABLED) begin
      to_cnt <= to_cnt + TO_WIDTH'(1);
    end
  end

  // Expiry fires in the cycle whose increment would reach TIMEOUT_CYCLES, so
  // mem_req is high for exactly TIMEOUT_CYCLES cycles before the abort.
  assign expire = ENABLED && enable && (to_cnt == LAST);

endmodule

// File: rtl/bf_bus_ctrl.sv
// BF bus controller. Converts each core bus request into either a req/ack
// transaction on the shared program/data memory or a valid/ready byte
// transfer on the IO streams, stalling the core via core_enable until done.
//
// Handshakes: mem_req is held high until the cycle in which mem_ack is seen
// (mem_ack is a one-cycle strobe carrying mem_rdata). On the IO streams a byte
// moves on any rising edge where valid and ready are both high; the side
// driving valid holds valid and data stable until that edge.
module bf_bus_ctrl
  import bf_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  BusOp                  core_bus_op,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [BUS_WIDTH-1:0]  core_val_out,
  output logic [BUS_WIDTH-1:0]  core_val_in,
  output logic                  core_enable,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic                  io_out_valid,
  output logic [BUS_WIDTH-1:0]  io_out_data,
  input  logic                  io_out_ready,
  output logic                  io_in_ready,
  input  logic [BUS_WIDTH-1:0]  io_in_data,
  input  logic                  io_in_valid,
  output logic                  busy,
  output logic                  timeout_err,
  output CtrlState              dbg_state
);

  CtrlState              state_q;
  BusOp                  op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]  wdata_q;
  logic [BUS_WIDTH-1:0]  rdata_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic                  out_valid_q;
  logic                  in_ready_q;
  logic                  timeout_q;
  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_expire;

  // Watchdog runs only while waiting on memory without an acknowledge.
  assign wd_enable = (state_q == MemWait) && !mem_ack;
  assign wd_clear  = (state_q != MemWait);

  bf_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_watchdog (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Transaction FSM with registered handshake outputs; reset drops any
  // in-flight transaction without completing it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= Idle;
      op_q        <= BusNone;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          // run gates only the start of a transaction, never one in flight.
          if ((core_bus_op != BusNone) && run) begin
            op_q    <= core_bus_op;
            addr_q  <= core_addr;
            wdata_q <= core_val_out;
            case (core_bus_op)
              BusReadProg, BusReadData, BusWriteData: begin
                state_q   <= MemWait;
                mem_req_q <= 1'b1;
                mem_we_q  <= (core_bus_op == BusWriteData);
              end
              BusWriteIo: begin
                state_q     <= OutWait;
                out_valid_q <= 1'b1;
              end
              BusReadIo: begin
                state_q    <= InWait;
                in_ready_q <= 1'b1;
              end
              // Unknown encodings complete immediately with no side effects.
              default: state_q <= Resume;
            endcase
          end
        end
        MemWait: begin
          // An acknowledge in the expiry cycle still completes normally.
          if (mem_ack) begin
            if (op_q != BusWriteData) rdata_q <= mem_rdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= Resume;
          end else if (wd_expire) begin
            if (op_q != BusWriteData) rdata_q <= '0;
            timeout_q <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= Resume;
          end
        end
        OutWait: begin
          if (io_out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= Resume;
          end
        end
        InWait: begin
          if (io_in_valid) begin
            rdata_q    <= io_in_data;
            in_ready_q <= 1'b0;
            state_q    <= Resume;
          end
        end
        // One enabled cycle lets the core step past its requesting state;
        // the op it still shows this cycle is therefore ignored.
        Resume:  state_q <= Idle;
        default: state_q <= Idle;
      endcase
    end
  end

  assign core_enable  = ((state_q == Idle) && run && (core_bus_op == BusNone)) ||
                        (state_q == Resume);
  assign core_val_in  = rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = {op_region(op_q), addr_q};
  assign mem_wdata    = wdata_q;
  assign io_out_valid = out_valid_q;
  assign io_out_data  = wdata_q;
  assign io_in_ready  = in_ready_q;
  assign busy         = (state_q != Idle);
  assign timeout_err  = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Bench for bf_bus_ctrl: the bench plays the core (driver task), the memory
// (responder with its own storage) and both IO endpoints.
module tb_bf_bus_ctrl;
  import bf_bus_ctrl_pkg::*;

  localparam int AW  = 15;
  localparam int BW  = 8;
  localparam int TO  = 4;
  localparam int TOW = 3;
  localparam int LW  = AW + BW + 2;  // {we, mem_addr, wdata}

  logic          clock = 1'b0;
  logic          reset_n;
  logic          run;
  BusOp          core_bus_op;
  logic [AW-1:0] core_addr;
  logic [BW-1:0] core_val_out;
  logic [BW-1:0] core_val_in;
  logic          core_enable;
  logic          mem_req;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;
  logic          mem_ack;
  logic          io_out_valid;
  logic [BW-1:0] io_out_data;
  logic          io_out_ready;
  logic          io_in_ready;
  logic [BW-1:0] io_in_data;
  logic          io_in_valid;
  logic          busy;
  logic          timeout_err;
  CtrlState      dbg_state;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  bf_bus_ctrl #(
    .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(TOW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .core_bus_op(core_bus_op), .core_addr(core_addr), .core_val_out(core_val_out),
    .core_val_in(core_val_in), .core_enable(core_enable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_out_valid(io_out_valid), .io_out_data(io_out_data), .io_out_ready(io_out_ready),
    .io_in_ready(io_in_ready), .io_in_data(io_in_data), .io_in_valid(io_in_valid),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- environment / reference state ----------------
  logic [BW-1:0] ext_mem [0:65535];  // memory behind the bus
  logic [BW-1:0] ref_mem [0:65535];  // model's view of memory contents
  logic [LW-1:0] mem_log[$];         // transactions the memory acknowledged
  logic [BW-1:0] out_log[$];         // bytes the sink accepted
  int            mem_lat = 1;        // ack in this MemWait cycle (1 = first)
  bit            mem_no_ack = 1'b0;
  int            out_lat = 0;        // cycles io_out_ready stays low
  int            in_lat = 0;         // cycles io_in_valid stays low
  logic [BW-1:0] in_byte = '0;
  logic [BW-1:0] cur_val = '0;       // expected core_val_in

  // results of the last core transaction
  int            t_stall, t_en, t_req, t_oval;
  bit            t_odata_ok;
  logic [BW-1:0] t_val;

  // Memory: acknowledges in cycle mem_lat of a request, logs each transfer.
  initial begin : mem_responder
    int cnt;
    logic [BW-1:0] wd;
    mem_ack = 1'b0; mem_rdata = '0; cnt = 0;
    forever begin
      @(posedge clock); #1;
      mem_ack = 1'b0;
      if (!mem_req) cnt = 0;
      else begin
        cnt++;
        if (!mem_no_ack && cnt == mem_lat) begin
          mem_ack = 1'b1;
          mem_rdata = ext_mem[mem_addr];
          wd = mem_we ? mem_wdata : 8'h00;
          if (mem_we) ext_mem[mem_addr] = mem_wdata;
          mem_log.push_back({mem_we, mem_addr, wd});
        end
      end
    end
  end

  // Output sink: holds ready low for out_lat cycles of each offered byte.
  initial begin : out_sink
    int cnt;
    io_out_ready = 1'b0; cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (!io_out_valid) begin cnt = 0; io_out_ready = 1'b0; end
      else begin
        cnt++;
        io_out_ready = (cnt == out_lat + 1);
        if (io_out_ready) out_log.push_back(io_out_data);
      end
    end
  end

  // Input source: offers in_byte after in_lat cycles of io_in_ready.
  initial begin : in_source
    int cnt;
    io_in_valid = 1'b0; io_in_data = '0; cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (!io_in_ready) begin cnt = 0; io_in_valid = 1'b0; end
      else begin
        cnt++;
        io_in_valid = (cnt == in_lat + 1);
        io_in_data  = in_byte;
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; presents op until core_enable, then
  // lets the core advance and returns just after the following edge.
  task automatic core_txn(input BusOp op, input logic [AW-1:0] addr, input logic [BW-1:0] wdata);
    bit done;
    done = 1'b0;
    t_stall = 0; t_en = 0; t_req = 0; t_oval = 0; t_odata_ok = 1'b1; t_val = 'x;
    core_bus_op = op; core_addr = addr; core_val_out = wdata;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      t_stall++;
      if (core_enable) t_en++;
      if (mem_req) t_req++;
      if (io_out_valid) begin
        t_oval++;
        if (io_out_data !== wdata) t_odata_ok = 1'b0;
      end
      done = core_enable;
      t_val = core_val_in;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL txn_complete op=%0d: core_enable never rose in 200 cycles, required a Resume", op);
    end
    @(posedge clock); #1;
    core_bus_op = BusNone;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; run = 1'b1;
    core_bus_op = BusNone; core_addr = '0; core_val_out = '0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if ({io_out_valid, io_in_ready} !== 2'b00) begin failures++; $display("FAIL reset_io got=%b%b exp=00", io_out_valid, io_in_ready); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    checks++; if (core_val_in !== 8'h00) begin failures++; $display("FAIL reset_val got=%h exp=00", core_val_in); end
    checks++; if (core_enable !== 1'b1) begin failures++; $display("FAIL reset_enable got=%b exp=1", core_enable); end
    checks++; if (dbg_state !== Idle) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, Idle); end
    @(posedge clock); #1;
    cur_val = 8'h00;
  endtask

  task automatic test_read_prog();
    ext_mem[16'h0010] = 8'h2B; ref_mem[16'h0010] = 8'h2B;
    mem_lat = 3;
    core_txn(BusReadProg, 15'h0010, 8'h00);
    cur_val = 8'h2B;
    checks++; if (t_val !== 8'h2B) begin failures++; $display("FAIL rp_val got=%h exp=2b", t_val); end
    checks++; if (t_stall !== 5 || t_en !== 1) begin failures++; $display("FAIL rp_stall got=%0d/%0d exp=5/1", t_stall, t_en); end
    checks++; if (t_req !== 3) begin failures++; $display("FAIL rp_req_cycles got=%0d exp=3", t_req); end
    checks++;
    if (mem_log.size() !== 1 || mem_log[0] !== {1'b0, 16'h0010, 8'h00}) begin
      failures++; $display("FAIL rp_mem_txn got n=%0d first=%h exp n=1 %h", mem_log.size(), mem_log.size() ? mem_log[0] : '0, {1'b0, 16'h0010, 8'h00});
    end
    mem_log.delete();
  endtask

  task automatic test_plus();
    ext_mem[16'h8000] = 8'h41; ref_mem[16'h8000] = 8'h41;
    mem_lat = 1;
    core_txn(BusReadData, 15'h0000, 8'h00);
    checks++; if (t_val !== 8'h41 || t_stall !== 3) begin failures++; $display("FAIL plus_read got=%h/%0d exp=41/3", t_val, t_stall); end
    core_txn(BusWriteData, 15'h0000, 8'h42);
    ref_mem[16'h8000] = 8'h42; cur_val = 8'h41;
    checks++; if (t_val !== 8'h41 || t_stall !== 3) begin failures++; $display("FAIL plus_write got=%h/%0d exp=41/3", t_val, t_stall); end
    checks++;
    if (mem_log.size() !== 2 || mem_log[0] !== {1'b0, 16'h8000, 8'h00} || mem_log[1] !== {1'b1, 16'h8000, 8'h42}) begin
      failures++; $display("FAIL plus_mem_txns got n=%0d exp read 08000 then write 08000=42", mem_log.size());
    end
    mem_log.delete();
  endtask

  task automatic test_out();
    out_lat = 5;
    core_txn(BusWriteIo, 15'h0000, 8'h42);
    checks++; if (t_oval !== 6 || !t_odata_ok) begin failures++; $display("FAIL out_valid_cycles got=%0d stable=%0d exp=6/1", t_oval, t_odata_ok); end
    checks++; if (t_stall !== 8 || t_en !== 1) begin failures++; $display("FAIL out_stall got=%0d/%0d exp=8/1", t_stall, t_en); end
    checks++;
    if (out_log.size() !== 1 || out_log[0] !== 8'h42) begin
      failures++; $display("FAIL out_transfer got n=%0d exp one byte 42", out_log.size());
    end
    checks++; if (t_val !== cur_val) begin failures++; $display("FAIL out_val got=%h exp=%h", t_val, cur_val); end
    out_log.delete();
  endtask

  task automatic test_in();
    in_lat = 3; in_byte = 8'h7A;
    core_txn(BusReadIo, 15'h0000, 8'h00);
    cur_val = 8'h7A;
    checks++; if (t_val !== 8'h7A || t_stall !== 6) begin failures++; $display("FAIL in_read got=%h/%0d exp=7a/6", t_val, t_stall); end
    mem_lat = 2;
    core_txn(BusWriteData, 15'h0005, t_val);
    ref_mem[16'h8005] = 8'h7A;
    checks++;
    if (mem_log.size() !== 1 || mem_log[0] !== {1'b1, 16'h8005, 8'h7A}) begin
      failures++; $display("FAIL in_store got n=%0d exp write 08005=7a", mem_log.size());
    end
    mem_log.delete();
  endtask

  task automatic test_run_gate();
    run = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++; if (core_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL gate_idle got en=%b busy=%b exp 0/0", core_enable, busy); end
    end
    @(posedge clock); #1;
    // op waits four cycles with run low, then is serviced once run rises
    mem_lat = 2;
    fork begin repeat (4) @(posedge clock); #1; run = 1'b1; end join_none
    core_txn(BusReadData, 15'h0003, 8'h00);
    cur_val = ref_mem[16'h8003];
    checks++; if (t_stall !== 8 || t_req !== 2) begin failures++; $display("FAIL gate_start got stall=%0d req=%0d exp 8/2", t_stall, t_req); end
    checks++; if (t_val !== cur_val) begin failures++; $display("FAIL gate_val got=%h exp=%h", t_val, cur_val); end
    // run falls after the request cycle: the transaction still completes
    mem_lat = 3;
    fork begin @(posedge clock); #1; run = 1'b0; end join_none
    core_txn(BusReadProg, 15'h0007, 8'h00);
    cur_val = ref_mem[16'h0007];
    checks++; if (t_stall !== 5 || t_val !== cur_val) begin failures++; $display("FAIL gate_inflight got stall=%0d val=%h exp 5/%h", t_stall, t_val, cur_val); end
    @(negedge clock);
    checks++; if (core_enable !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL gate_frozen got en=%b req=%b exp 0/0", core_enable, mem_req); end
    @(posedge clock); #1; run = 1'b1;
    mem_log.delete();
  endtask

  task automatic test_unknown_op();
    core_txn(BusOp'(3'd6), 15'h0001, 8'hEE);
    checks++; if (t_stall !== 2 || t_req !== 0 || t_val !== cur_val) begin
      failures++; $display("FAIL unknown_op got stall=%0d req=%0d val=%h exp 2/0/%h", t_stall, t_req, t_val, cur_val);
    end
    checks++; if (mem_log.size() !== 0) begin failures++; $display("FAIL unknown_mem got n=%0d exp 0", mem_log.size()); end
  endtask

  task automatic test_random();
    BusOp op;
    logic [AW-1:0] a;
    logic [AW:0] full;
    logic [BW-1:0] wd, exp_val;
    logic [LW-1:0] exp_q[$];
    int k, exp_stall;
    bit exp_out;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: op = BusReadProg;
        1: op = BusReadData;
        2: op = BusWriteData;
        3: op = BusWriteIo;
        4: op = BusReadIo;
        5: op = BusWriteData;
        default: op = BusOp'(3'd7);
      endcase
      a = AW'($urandom_range(0, 15));
      wd = BW'($urandom);
      mem_lat = $urandom_range(1, TO);
      out_lat = $urandom_range(0, 3);
      in_lat = $urandom_range(0, 3);
      in_byte = BW'($urandom);
      full = {(op == BusReadData || op == BusWriteData) ? 1'b1 : 1'b0, a};
      exp_val = cur_val; exp_out = 1'b0; exp_stall = 2;
      if (op == BusReadProg || op == BusReadData) begin
        exp_val = ref_mem[full]; exp_stall = 2 + mem_lat;
        exp_q.push_back({1'b0, full, 8'h00});
      end else if (op == BusWriteData) begin
        ref_mem[full] = wd; exp_stall = 2 + mem_lat;
        exp_q.push_back({1'b1, full, wd});
      end else if (op == BusWriteIo) begin
        exp_out = 1'b1; exp_stall = 3 + out_lat;
      end else if (op == BusReadIo) begin
        exp_val = in_byte; exp_stall = 3 + in_lat;
      end
      core_txn(op, a, wd);
      cur_val = exp_val;
      checks++; if (t_val !== exp_val) begin failures++; $display("FAIL rnd_val n=%0d op=%0d got=%h exp=%h", n, op, t_val, exp_val); end
      checks++; if (t_stall !== exp_stall || t_en !== 1) begin failures++; $display("FAIL rnd_stall n=%0d op=%0d got=%0d/%0d exp=%0d/1", n, op, t_stall, t_en, exp_stall); end
      checks++;
      if (mem_log.size() !== exp_q.size() || (exp_q.size() == 1 && mem_log[0] !== exp_q[0])) begin
        failures++; $display("FAIL rnd_mem n=%0d got n=%0d exp n=%0d %h", n, mem_log.size(), exp_q.size(), exp_q.size() ? exp_q[0] : '0);
      end
      checks++;
      if (out_log.size() !== int'(exp_out) || (exp_out && out_log[0] !== wd)) begin
        failures++; $display("FAIL rnd_out n=%0d got n=%0d exp n=%0d byte=%h", n, out_log.size(), exp_out, wd);
      end
      mem_log.delete(); out_log.delete(); exp_q.delete();
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic test_ack_boundary();
    mem_lat = TO;
    core_txn(BusReadData, 15'h0009, 8'h00);
    cur_val = ref_mem[16'h8009];
    checks++; if (t_val !== cur_val || t_stall !== TO + 2) begin failures++; $display("FAIL ack_last got val=%h stall=%0d exp %h/%0d", t_val, t_stall, cur_val, TO + 2); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL ack_last_err got=%b exp=0", timeout_err); end
    mem_log.delete();
  endtask

  task automatic test_timeout();
    ext_mem[16'h8001] = 8'h5C; ref_mem[16'h8001] = 8'h5C;
    mem_lat = 1;
    core_txn(BusReadData, 15'h0001, 8'h00);
    cur_val = 8'h5C;
    mem_no_ack = 1'b1;
    core_txn(BusWriteData, 15'h0002, 8'h99);
    checks++; if (t_val !== 8'h5C || t_req !== TO) begin failures++; $display("FAIL to_write got val=%h req=%0d exp 5c/%0d", t_val, t_req, TO); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    core_txn(BusReadData, 15'h0001, 8'h00);
    cur_val = 8'h00;
    checks++; if (t_val !== 8'h00 || t_req !== TO || t_stall !== TO + 2) begin
      failures++; $display("FAIL to_read got val=%h req=%0d stall=%0d exp 00/%0d/%0d", t_val, t_req, t_stall, TO, TO + 2);
    end
    mem_no_ack = 1'b0;
    mem_lat = 2;
    core_txn(BusReadProg, 15'h0004, 8'h00);
    cur_val = ref_mem[16'h0004];
    checks++; if (t_val !== cur_val || timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got val=%h err=%b exp %h/1", t_val, timeout_err, cur_val); end
    checks++; if (mem_log.size() !== 2) begin failures++; $display("FAIL to_mem_count got=%0d exp=2", mem_log.size()); end
    mem_log.delete();
  endtask

  task automatic test_async_reset();
    mem_no_ack = 1'b1;
    core_bus_op = BusReadData; core_addr = 15'h0004; core_val_out = '0;
    repeat (3) @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL ar_pending got=%b exp=1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || dbg_state !== Idle) begin
      failures++; $display("FAIL ar_drop got req=%b busy=%b state=%0d exp 0/0/%0d", mem_req, busy, dbg_state, Idle);
    end
    checks++; if (core_val_in !== 8'h00 || timeout_err !== 1'b0) begin failures++; $display("FAIL ar_regs got val=%h err=%b exp 00/0", core_val_in, timeout_err); end
    core_bus_op = BusNone; mem_no_ack = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    mem_lat = 2;
    core_txn(BusReadData, 15'h0004, 8'h00);
    cur_val = ref_mem[16'h8004];
    checks++; if (t_val !== cur_val || t_stall !== 4) begin failures++; $display("FAIL ar_after got val=%h stall=%0d exp %h/4", t_val, t_stall, cur_val); end
    checks++;
    if (mem_log.size() !== 1 || mem_log[0] !== {1'b0, 16'h8004, 8'h00}) begin
      failures++; $display("FAIL ar_mem got n=%0d exp one read of 08004", mem_log.size());
    end
    mem_log.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      ext_mem[i] = BW'($urandom);
      ref_mem[i] = ext_mem[i];
    end
    test_reset();
    test_read_prog();
    test_plus();
    test_out();
    test_in();
    test_run_gate();
    test_unknown_op();
    test_random();
    test_ack_boundary();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached at %0t, expected completion earlier", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bf_bus_ctrl.md
Name: bf_bus_ctrl

Overview:
Bus controller between the BF interpreter core and the outside world. It turns each core bus request into a request/acknowledge transaction on one shared program/data memory, or into a valid/ready transfer on the byte IO streams. It stalls the core through its enable input until the transaction completes, then presents read data on the core's val_in. It also provides a run gate and a memory timeout watchdog with a sticky error flag.

Parameters:
ADDR_WIDTH, 15, core address width
BUS_WIDTH, 8, core/IO data width
TIMEOUT_CYCLES, 255, maximum mem_req cycles without mem_ack before abort; 0 disables the watchdog
TO_WIDTH, 8, watchdog counter width; must be >= clog2(TIMEOUT_CYCLES+1)

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
run  in  1  allows the core to advance when the controller is idle
core_bus_op  in  BusOp  request from the core
core_addr  in  ADDR_WIDTH  core address
core_val_out  in  BUS_WIDTH  core write data
core_val_in  out  BUS_WIDTH  read data returned to the core
core_enable  out  1  core clock-enable; low = core stalled
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH+1  {region, addr}; region 0 = program, 1 = data
mem_wdata  out  BUS_WIDTH  write data
mem_rdata  in  BUS_WIDTH  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe
io_out_valid  out  1  output byte valid
io_out_data  out  BUS_WIDTH  output byte
io_out_ready  in  1  sink accepts
io_in_ready  out  1  controller wants an input byte
io_in_data  in  BUS_WIDTH  input byte
io_in_valid  in  1  source offers
busy  out  1  transaction in flight (state != Idle)
timeout_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (async, reset_n=0): state=Idle; rdata_q=0; timeout_err=0; to_cnt=0; mem_req, io_out_valid and io_in_ready low. Any in-flight transaction is dropped without completion.
- States: Idle, MemWait, OutWait, InWait, Resume.
- core_enable (combinational) = (Idle && run && core_bus_op==BusNone) || Resume.
- Idle:
  - If core_bus_op != BusNone: core_enable=0 in the same cycle, regardless of run. Latch op, addr and val_out into op_q, addr_q and wdata_q.
  - BusReadProg, BusReadData, BusWriteData -> MemWait. BusWriteIo -> OutWait. BusReadIo -> InWait.
  - Unknown op encodings -> Resume with rdata_q unchanged.
- MemWait: mem_req=1.
  - mem_we=1 only for BusWriteData.
  - mem_addr={op_q==BusReadData||op_q==BusWriteData, addr_q}; mem_wdata=wdata_q.
  - On mem_ack: reads capture mem_rdata into rdata_q; go to Resume.
  - to_cnt increments each cycle without ack. When to_cnt reaches TIMEOUT_CYCLES (and it is nonzero): drop mem_req, set timeout_err, load rdata_q=0 for reads, go to Resume. A mem_ack arriving in the abort cycle wins over the timeout.
- OutWait: io_out_valid=1, io_out_data=wdata_q. On io_out_ready go to Resume. Blocks indefinitely; no timeout.
- InWait: io_in_ready=1. On io_in_valid capture io_in_data into rdata_q and go to Resume. Blocks indefinitely.
- Resume: core_enable=1 for exactly one cycle and the core advances past the requesting state. The op still visible this cycle is ignored. Next state is Idle; to_cnt is cleared.
- core_val_in = rdata_q at all times. It changes only on a read completion or timeout, so it stays stable through the core's decode/load state that follows.
- Minimum stall: request cycle, one MemWait cycle with immediate ack, Resume = 3 cycles per bus op. Back-to-back core ops are each serviced in turn.
- run=0 in Idle: core frozen and no new transactions start. run is not checked inside a transaction, so an in-flight transaction completes and gets its Resume.
- Sequential logic uses clock and asynchronous negedge reset_n; there are no other clocks.

Decomposition:
- The shared package holds BusOp (reused unchanged), CtrlState enum, and constants REGION_PROG=1'b0 and REGION_DATA=1'b1.
- One natural sub-module: bf_bus_watchdog (to_cnt, clear/enable inputs, expire output), instantiated once.
- The core instance connects its enable to core_enable; the core's reset polarity is inverted at the top level.

Test Plan:
- BusReadProg addr=0x0010, mem_ack 2 cycles after mem_req with rdata=0x2B -> mem_addr=0x00010, mem_we=0; core_val_in=0x2B; core_enable high exactly in Resume.
- Program "+" with cell[0]=0x41 -> data read at mem_addr=0x08000, then write mem_we=1 with mem_wdata=0x42, same address.
- "." with io_out_ready held low 5 cycles -> io_out_valid/io_out_data=0x42 stable for 6 cycles, core_enable=0 throughout, one transfer.
- "," with io_in_valid and 0x7A after 3 cycles -> rdata_q=0x7A, data write of 0x7A at the cursor address.
- TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops after 4 cycles; timeout_err=1 and sticky; core_val_in=0x00; core resumes.
- reset_n low mid-MemWait -> mem_req=0 immediately (async), state=Idle, rdata_q=0; after release the first op is serviced normally. run=0 in Idle -> core_enable=0 and no mem_req.
